// File: rtl/mdclcg_pkg.sv
// Shared types and constants for the modified dual-CLCG controller.
package mdclcg_pkg;

    localparam int SEED_W     = 16;
    localparam int PARAM_W    = 4;
    localparam int LANE_W     = 4;
    localparam int DEF_WORD_W = 16;
    localparam int DEF_WARMUP = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WARM,
        ST_RUN
    } state_e;

    typedef struct packed {
        logic [SEED_W-1:0]   seed;
        logic [4*LANE_W-1:0] a;
        logic [4*LANE_W-1:0] b;
        logic [PARAM_W-1:0]  m;
        logic [PARAM_W-1:0]  r;
    } cfg_t;

endpackage

// File: rtl/mdclcg_packer.sv
// Serial-to-parallel packer: collects z_i bits MSB-first into words and
// holds one completed word for the consumer, flagging drops as overflow.
module mdclcg_packer #(
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              collect,
    input  logic              bit_in,
    input  logic              out_ready,
    input  logic              ovf_clr,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    output logic              overflow
);

    localparam int                CNT_W    = $clog2(WORD_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WORD_W - 1);

    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              vld_q, vld_d;
    logic              ovf_q, ovf_d;
    logic              done;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        vld_d   = vld_q;
        ovf_d   = ovf_q;
        done    = collect && (cnt_q == CNT_LAST);

        if (ovf_clr) ovf_d = 1'b0;

        if (clr) begin
            shreg_d = '0;
            cnt_d   = '0;
        end else if (collect) begin
            shreg_d = {shreg_q[WORD_W-2:0], bit_in};
            cnt_d   = done ? '0 : cnt_q + CNT_W'(1);
        end

        // A completed word may replace the held one only if it is leaving this cycle.
        if (done && (!vld_q || out_ready)) begin
            data_d = shreg_d;
            vld_d  = 1'b1;
        end else if (done) begin
            ovf_d = 1'b1;
        end else if (vld_q && out_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = vld_q;
    assign overflow  = ovf_q;

endmodule

// File: rtl/mdclcg_ctrl.sv
// Sequencer for the modified dual-CLCG datapath: config handshake, start
// pulse, warm-up discard and word packing of the z_i stream.
module mdclcg_ctrl
    import mdclcg_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int WARMUP = DEF_WARMUP
) (
    input  logic                clk1,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [SEED_W-1:0]   cfg_seed,
    input  logic [4*LANE_W-1:0] cfg_a,
    input  logic [4*LANE_W-1:0] cfg_b,
    input  logic [PARAM_W-1:0]  cfg_m,
    input  logic [PARAM_W-1:0]  cfg_r,
    input  logic                stop,
    input  logic                en,
    output logic                dp_start,
    output logic [SEED_W-1:0]   dp_seed,
    output logic [4*LANE_W-1:0] dp_a,
    output logic [4*LANE_W-1:0] dp_b,
    output logic [PARAM_W-1:0]  dp_m,
    output logic [PARAM_W-1:0]  dp_r,
    input  logic                z_i,
    output logic [WORD_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                overflow,
    output logic                cfg_err
);

    localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);

    state_e     state_q, state_d;
    cfg_t       cfg_q, cfg_d;
    logic [7:0] warm_q, warm_d;
    logic       dp_start_q, dp_start_d;
    logic       cfg_err_q, cfg_err_d;
    logic       stop_eff, cfg_hs, cfg_ok, collect;

    assign cfg_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign busy      = (state_q != ST_IDLE);

    // stop outranks a simultaneous config, but has no effect while idle.
    assign stop_eff = stop && (state_q != ST_IDLE);
    assign cfg_hs   = cfg_valid && cfg_ready && !stop_eff;
    assign cfg_ok   = cfg_hs && (cfg_m != '0);
    assign collect  = (state_q == ST_RUN) && en && !stop_eff && !cfg_ok;

    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        warm_d     = warm_q;
        dp_start_d = cfg_ok;
        cfg_err_d  = cfg_hs && (cfg_m == '0);

        if (stop_eff) begin
            state_d = ST_IDLE;
        end else if (cfg_ok) begin
            state_d    = ST_LOAD;
            cfg_d.seed = cfg_seed;
            cfg_d.a    = cfg_a;
            cfg_d.b    = cfg_b;
            cfg_d.m    = cfg_m;
            cfg_d.r    = cfg_r;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    warm_d  = '0;
                    state_d = (WARMUP == 0) ? ST_RUN : ST_WARM;
                end
                ST_WARM: begin
                    if (warm_q == WARM_LAST) state_d = ST_RUN;
                    else                     warm_d  = warm_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cfg_q      <= '0;
            warm_q     <= '0;
            dp_start_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            warm_q     <= warm_d;
            dp_start_q <= dp_start_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign dp_start = dp_start_q;
    assign cfg_err  = cfg_err_q;
    assign dp_seed  = cfg_q.seed;
    assign dp_a     = cfg_q.a;
    assign dp_b     = cfg_q.b;
    assign dp_m     = cfg_q.m;
    assign dp_r     = cfg_q.r;

    mdclcg_packer #(
        .WORD_W(WORD_W)
    ) u_packer (
        .clk      (clk1),
        .rst_n    (rst),
        .clr      (state_q == ST_LOAD),
        .collect  (collect),
        .bit_in   (z_i),
        .out_ready(out_ready),
        .ovf_clr  (cfg_ok),
        .out_data (out_data),
        .out_valid(out_valid),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_mdclcg_ctrl.sv
// Randomized and directed bench for mdclcg_ctrl against a time-since-start
// reference model with a queue of collected bits.
module tb_mdclcg_ctrl;

    localparam int WW = 16;
    localparam int WU = 8;

    logic          clk1 = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0, stop = 1'b0, en = 1'b0, z_i = 1'b0, out_ready = 1'b0;
    logic [15:0]   cfg_seed = '0, cfg_a = '0, cfg_b = '0;
    logic [3:0]    cfg_m = '0, cfg_r = '0;
    logic          cfg_ready, dp_start, out_valid, busy, overflow, cfg_err;
    logic [15:0]   dp_seed, dp_a, dp_b;
    logic [3:0]    dp_m, dp_r;
    logic [WW-1:0] out_data;

    always #5 clk1 = ~clk1;

    mdclcg_ctrl #(.WORD_W(WW), .WARMUP(WU)) dut (
        .clk1(clk1), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_seed(cfg_seed), .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_m(cfg_m), .cfg_r(cfg_r),
        .stop(stop), .en(en), .dp_start(dp_start), .dp_seed(dp_seed), .dp_a(dp_a),
        .dp_b(dp_b), .dp_m(dp_m), .dp_r(dp_r), .z_i(z_i), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .overflow(overflow),
        .cfg_err(cfg_err)
    );

    int n_chk, n_pass;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: m_t counts cycles since the start cycle (0 = start pulse).
    bit          m_idle;
    int          m_t, run_cnt;
    bit          bits[$];
    logic [WW-1:0] e_od;
    logic        e_ov, e_ovf, e_err;
    logic [15:0] e_seed, e_a, e_b;
    logic [3:0]  e_m, e_r;
    int          zmode, enmode;

    task automatic mdl_reset();
        m_idle = 1; m_t = 0; run_cnt = 0; bits.delete();
        e_od = '0; e_ov = 0; e_ovf = 0; e_err = 0;
        e_seed = '0; e_a = '0; e_b = '0; e_m = '0; e_r = '0;
    endtask

    task automatic mdl_step();
        bit run, stp, acc, good, done;
        logic [WW-1:0] w;
        run  = !m_idle && (m_t > WU);
        stp  = stop && !m_idle;
        acc  = cfg_valid && (m_idle || run) && !stp;
        good = acc && (cfg_m != 0);
        e_err = acc && (cfg_m == 0);
        done = 0;
        if (run && en && !stp && !good) begin
            bits.push_back(z_i);
            if (bits.size() == WW) begin
                done = 1;
                w = '0;
                foreach (bits[i]) w = (w << 1) | WW'(bits[i]);
                bits.delete();
                if (!e_ov || out_ready) begin e_od = w; e_ov = 1; end
                else e_ovf = 1;
            end
        end
        if (!done && e_ov && out_ready) e_ov = 0;
        if (run && !stp && !good) run_cnt++;
        if (good) begin
            e_seed = cfg_seed; e_a = cfg_a; e_b = cfg_b; e_m = cfg_m; e_r = cfg_r;
            e_ovf = 0; m_idle = 0; m_t = 0; run_cnt = 0; bits.delete();
        end else if (stp) begin
            m_idle = 1; bits.delete();
        end else if (!m_idle) begin
            m_t++;
        end
    endtask

    task automatic compare();
        chk("out_valid", out_valid, e_ov);
        chk("out_data",  out_data,  e_od);
        chk("overflow",  overflow,  e_ovf);
        chk("cfg_err",   cfg_err,   e_err);
        chk("dp_start",  dp_start,  !m_idle && m_t == 0);
        chk("busy",      busy,      !m_idle);
        chk("cfg_ready", cfg_ready, m_idle || m_t > WU);
        chk("dp_seed", dp_seed, e_seed);
        chk("dp_a", dp_a, e_a);
        chk("dp_b", dp_b, e_b);
        chk("dp_m", dp_m, e_m);
        chk("dp_r", dp_r, e_r);
    endtask

    task automatic cyc();
        if (zmode == 0)      z_i = 1'($urandom_range(0, 1));
        else if (zmode == 1) z_i = (run_cnt % 2 == 0);
        else                 z_i = 1'b1;
        if (enmode == 0)      en = 1'($urandom_range(0, 1));
        else if (enmode == 2) en = ~en;
        else                  en = 1'b1;
        @(posedge clk1);
        mdl_step();
        #1;
        compare();
    endtask

    task automatic send_cfg(input logic [15:0] s, input logic [3:0] m);
        cfg_seed = s; cfg_a = 16'h3579; cfg_b = 16'h1357; cfg_m = m; cfg_r = 4'd3;
        cfg_valid = 1'b1;
        cyc();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_valid(output int k, input int lim);
        k = 0;
        do begin cyc(); k++; end while (!out_valid && k < lim);
        chk("wait_valid", out_valid, 1'b1);
    endtask

    initial begin
        int k;
        n_chk = 0; n_pass = 0;
        zmode = 1; enmode = 1;
        mdl_reset();
        #1 rst = 1'b0;
        #1 compare();
        @(posedge clk1); #2 rst = 1'b1;

        // basic run
        out_ready = 1'b1;
        send_cfg(16'hA5C3, 4'd4);
        chk("start_pulse", dp_start, 1'b1);
        chk("seed_basic", dp_seed, 16'hA5C3);
        wait_valid(k, 40);
        chk("first_lat", k, WU + 1 + WW);
        chk("word_aaaa", out_data, 16'hAAAA);
        wait_valid(k, 40);
        chk("word_period", k, WW);

        // backpressure
        out_ready = 1'b0;
        repeat (40) cyc();
        chk("bp_ovf", overflow, 1'b1);
        chk("bp_hold_vld", out_valid, 1'b1);
        chk("bp_hold_data", out_data, 16'hAAAA);
        out_ready = 1'b1;
        cyc();
        send_cfg(16'h5A5A, 4'd5);
        chk("ovf_cleared", overflow, 1'b0);

        // en gating
        zmode = 2; enmode = 2;
        repeat (2) cyc();
        wait_valid(k, 80);
        chk("en_gate_data", out_data, 16'hFFFF);

        // mid-word reseed
        zmode = 1; enmode = 1;
        send_cfg(16'h0F0F, 4'd3);
        repeat (WU + 1 + 5) cyc();
        send_cfg(16'h1234, 4'd7);
        chk("reseed_start", dp_start, 1'b1);
        chk("reseed_seed", dp_seed, 16'h1234);
        wait_valid(k, 40);
        chk("reseed_lat", k, WU + 1 + WW);
        chk("reseed_data", out_data, 16'hAAAA);

        // reject and stop
        send_cfg(16'hFFFF, 4'd0);
        chk("rej_err", cfg_err, 1'b1);
        chk("rej_seed", dp_seed, 16'h1234);
        chk("rej_busy", busy, 1'b1);
        cyc();
        send_cfg(16'h4321, 4'd1);
        repeat (3) cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stop_busy", busy, 1'b0);
        chk("stop_ready", cfg_ready, 1'b1);

        // asynchronous reset mid-RUN
        send_cfg(16'h7777, 4'd9);
        out_ready = 1'b0;
        repeat (60) cyc();
        chk("pre_rst_ovf", overflow, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("arst_vld", out_valid, 1'b0);
        chk("arst_ovf", overflow, 1'b0);
        chk("arst_start", dp_start, 1'b0);
        mdl_reset();
        compare();
        @(posedge clk1); #1;
        compare();
        rst = 1'b1;

        // random traffic
        zmode = 0; enmode = 0;
        for (int i = 0; i < 3000; i++) begin
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_seed  = 16'($urandom);
            cfg_a     = 16'($urandom);
            cfg_b     = 16'($urandom);
            cfg_m     = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            cfg_r     = 4'($urandom);
            stop      = ($urandom_range(0, 39) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
